// File: rtl/seq_divider32.sv
// Iterative restoring divider: one shift-and-subtract step per clock, with an
// early-out for divide-by-zero and signed MIN / -1, and a final sign-fix step.
module seq_divider32 #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             div_by_zero,
  output logic             ovf
);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [WIDTH-1:0] a_reg, a_next;
  logic [WIDTH-1:0] b_reg, b_next;
  logic             signed_reg, signed_next;
  logic [WIDTH-1:0] dmag_reg, dmag_next;
  logic [WIDTH-1:0] rem_reg, rem_next;
  logic [WIDTH-1:0] quo_reg, quo_next;
  logic             neg_q_reg, neg_q_next;
  logic             neg_r_reg, neg_r_next;
  logic [WIDTH-1:0] q_reg, q_next;
  logic [WIDTH-1:0] r_reg, r_next;
  logic             dbz_reg, dbz_next;
  logic             ovf_reg, ovf_next;

  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] trial;

  // The shifted partial remainder never exceeds WIDTH+1 bits; the extra top
  // bit of trial is the borrow that decides restore vs. keep.
  assign shifted = {rem_reg, quo_reg[WIDTH-1]};
  assign trial   = {1'b0, shifted} - {2'b00, dmag_reg};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    a_next      = a_reg;
    b_next      = b_reg;
    signed_next = signed_reg;
    dmag_next   = dmag_reg;
    rem_next    = rem_reg;
    quo_next    = quo_reg;
    neg_q_next  = neg_q_reg;
    neg_r_next  = neg_r_reg;
    q_next      = q_reg;
    r_next      = r_reg;
    dbz_next    = dbz_reg;
    ovf_next    = ovf_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          a_next      = a;
          b_next      = b;
          signed_next = is_signed;
          quo_next    = (is_signed && a[WIDTH-1]) ? (~a + ONE) : a;
          dmag_next   = (is_signed && b[WIDTH-1]) ? (~b + ONE) : b;
          rem_next    = '0;
          neg_q_next  = is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
          neg_r_next  = is_signed && a[WIDTH-1];
          cnt_next    = '0;
          state_next  = RUN;
        end
      end
      RUN: begin
        if (cnt_reg == '0 && b_reg == '0) begin
          q_next     = ALL_ONES;
          r_next     = a_reg;
          dbz_next   = 1'b1;
          ovf_next   = 1'b0;
          state_next = DONE;
        end else if (cnt_reg == '0 && signed_reg && a_reg == MIN_VAL && b_reg == ALL_ONES) begin
          q_next     = MIN_VAL;
          r_next     = '0;
          dbz_next   = 1'b0;
          ovf_next   = 1'b1;
          state_next = DONE;
        end else begin
          quo_next = {quo_reg[WIDTH-2:0], ~trial[WIDTH+1]};
          rem_next = trial[WIDTH+1] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
          cnt_next = cnt_reg + CNT_ONE;
          if (cnt_reg == LAST_CNT) state_next = FIX;
        end
      end
      FIX: begin
        q_next     = neg_q_reg ? (~quo_reg + ONE) : quo_reg;
        r_next     = neg_r_reg ? (~rem_reg + ONE) : rem_reg;
        dbz_next   = 1'b0;
        ovf_next   = 1'b0;
        state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg    <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      signed_reg <= 1'b0;
      dmag_reg   <= '0;
      rem_reg    <= '0;
      quo_reg    <= '0;
      neg_q_reg  <= 1'b0;
      neg_r_reg  <= 1'b0;
      q_reg      <= '0;
      r_reg      <= '0;
      dbz_reg    <= 1'b0;
      ovf_reg    <= 1'b0;
    end else begin
      cnt_reg    <= cnt_next;
      a_reg      <= a_next;
      b_reg      <= b_next;
      signed_reg <= signed_next;
      dmag_reg   <= dmag_next;
      rem_reg    <= rem_next;
      quo_reg    <= quo_next;
      neg_q_reg  <= neg_q_next;
      neg_r_reg  <= neg_r_next;
      q_reg      <= q_next;
      r_reg      <= r_next;
      dbz_reg    <= dbz_next;
      ovf_reg    <= ovf_next;
    end
  end

  assign busy        = (state_reg == RUN) || (state_reg == FIX);
  assign done        = (state_reg == DONE);
  assign q           = q_reg;
  assign r           = r_reg;
  assign div_by_zero = dbz_reg;
  assign ovf         = ovf_reg;

endmodule

// File: tb/tb_seq_divider32.sv
// Randomized and directed bench for seq_divider32, checked against a plain
// arithmetic model of quotient, remainder, flags and latency.
module tb_seq_divider32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        is_signed = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy, done, div_by_zero, ovf;
  logic [31:0] q, r;

  int n_checks = 0;
  int n_pass   = 0;

  seq_divider32 #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .is_signed(is_signed),
    .a(a), .b(b), .busy(busy), .done(done), .q(q), .r(r),
    .div_by_zero(div_by_zero), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
  endtask

  // Reference: language-level division, with the two special cases spelled out.
  task automatic ref_div(input bit sgn, input logic [31:0] aa, input logic [31:0] bb,
                         output logic [31:0] eq, output logic [31:0] er,
                         output logic edbz, output logic eovf, output int lat);
    int sa, sb;
    sa = $signed(aa);
    sb = $signed(bb);
    edbz = 1'b0; eovf = 1'b0; lat = 34;
    if (bb == 32'd0) begin
      eq = 32'hFFFF_FFFF; er = aa; edbz = 1'b1; lat = 2;
    end else if (sgn && aa == 32'h8000_0000 && bb == 32'hFFFF_FFFF) begin
      eq = 32'h8000_0000; er = 32'd0; eovf = 1'b1; lat = 2;
    end else if (sgn) begin
      eq = 32'(sa / sb); er = 32'(sa % sb);
    end else begin
      eq = aa / bb; er = aa % bb;
    end
  endtask

  task automatic do_op(input bit sgn, input logic [31:0] aa, input logic [31:0] bb,
                       input int poke_k, input bit done_poke);
    logic [31:0] eq, er, prev_q;
    logic        edbz, eovf;
    int          lat, done_k, busy_cycles;
    ref_div(sgn, aa, bb, eq, er, edbz, eovf, lat);
    prev_q = q;
    done_k = 0;
    busy_cycles = 0;
    @(negedge clk);
    is_signed = sgn; a = aa; b = bb; start = 1'b1;
    for (int k = 1; k <= 45; k++) begin
      @(negedge clk);
      if (k == 1) begin
        start = 1'b0;
        a = $urandom; b = $urandom; is_signed = $urandom_range(0, 1);
        check_val("hold_prev_q", q, prev_q);
      end
      if (k == poke_k) begin
        start = 1'b1; a = $urandom; b = $urandom;
      end else if (k == poke_k + 1) begin
        start = 1'b0;
      end
      if (done) begin
        done_k = k;
        break;
      end
      if (busy) busy_cycles++;
    end
    check_val("latency", 32'(done_k), 32'(lat));
    check_val("busy_cycles", 32'(busy_cycles), 32'(lat - 1));
    check_val("busy_at_done", {31'd0, busy}, 32'd0);
    check_val("q", q, eq);
    check_val("r", r, er);
    check_val("div_by_zero", {31'd0, div_by_zero}, {31'd0, edbz});
    check_val("ovf", {31'd0, ovf}, {31'd0, eovf});
    $display("op sgn=%0d a=%08h b=%08h -> q=%08h r=%08h dbz=%0d ovf=%0d lat=%0d",
             sgn, aa, bb, q, r, div_by_zero, ovf, done_k);
    if (done_poke) begin
      start = 1'b1; a = 32'd50; b = 32'd5;
    end
    @(negedge clk);
    start = 1'b0;
    check_val("done_pulse", {31'd0, done}, 32'd0);
    check_val("idle_after_done", {31'd0, busy}, 32'd0);
    if (done_poke) begin
      @(negedge clk);
      check_val("start_in_done_ignored", {31'd0, busy}, 32'd0);
    end
  endtask

  initial begin
    logic [31:0] ra, rb;
    bit          rs;
    int          done_hits;

    #2;
    check_val("rst_busy", {31'd0, busy}, 32'd0);
    check_val("rst_done", {31'd0, done}, 32'd0);
    check_val("rst_q", q, 32'd0);
    check_val("rst_r", r, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    do_op(1'b0, 32'd100, 32'd7, -1, 1'b0);
    do_op(1'b1, 32'hFFFF_FF9C, 32'd7, -1, 1'b0);
    do_op(1'b1, 32'd100, 32'hFFFF_FFF9, -1, 1'b0);
    do_op(1'b0, 32'hFFFF_FFFF, 32'd1, -1, 1'b0);
    do_op(1'b0, 32'h1234_5678, 32'h1234_5679, -1, 1'b0);
    do_op(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, 1'b0);
    do_op(1'b0, 32'hDEAD_BEEF, 32'd0, -1, 1'b0);
    do_op(1'b1, 32'hDEAD_BEEF, 32'd0, -1, 1'b0);
    do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, -1, 1'b0);
    do_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, -1, 1'b0);
    do_op(1'b1, 32'h8000_0000, 32'd3, -1, 1'b0);
    do_op(1'b0, 32'd123456, 32'd789, 5, 1'b1);

    // Reset in the middle of an operation.
    @(negedge clk);
    is_signed = 1'b0; a = 32'd12345; b = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_val("midrst_busy", {31'd0, busy}, 32'd0);
    check_val("midrst_done", {31'd0, done}, 32'd0);
    check_val("midrst_q", q, 32'd0);
    check_val("midrst_r", r, 32'd0);
    check_val("midrst_dbz", {31'd0, div_by_zero}, 32'd0);
    check_val("midrst_ovf", {31'd0, ovf}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    done_hits = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) done_hits++;
    end
    check_val("no_done_after_rst", 32'(done_hits), 32'd0);
    do_op(1'b0, 32'd1000, 32'd10, -1, 1'b0);

    for (int i = 0; i < 40; i++) begin
      rs = $urandom_range(0, 1);
      ra = $urandom;
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 16));
        2:       rb = 32'hFFFF_FFFF;
        3: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        4:       rb = 32'($urandom_range(1, 65535));
        default: rb = $urandom;
      endcase
      do_op(rs, ra, rb, -1, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
